// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and constants for the PC generator
package pc_gen_pkg;

  typedef enum logic {BOOT, RUN} state_t;

  // Numeric order is redirect priority: larger value wins.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    JUMP   = 2'd1,
    BRANCH = 2'd2,
    TRAP   = 2'd3
  } src_t;

  localparam int DEFAULT_INC = 4;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// rtl/pc_redirect_arbiter.sv - combinational redirect priority select (trap > branch > jump)
module pc_redirect_arbiter
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            pend_valid,
  input  src_t            pend_src,
  input  logic [XLEN-1:0] pend_target,
  output src_t            live_src,
  output logic [XLEN-1:0] live_target,
  output src_t            sel_src,
  output logic [XLEN-1:0] sel_target
);

  always_comb begin
    live_src    = NONE;
    live_target = '0;
    if (trap_valid) begin
      live_src    = TRAP;
      live_target = trap_target;
    end else if (branch_valid) begin
      live_src    = BRANCH;
      live_target = branch_target;
    end else if (jump_valid) begin
      live_src    = JUMP;
      live_target = jump_target;
    end

    // An already-buffered redirect beats a live one of equal rank.
    sel_src    = live_src;
    sel_target = live_target;
    if (pend_valid && (pend_src >= live_src)) begin
      sel_src    = pend_src;
      sel_target = pend_target;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch program-counter generator with buffered redirects
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = DEFAULT_INC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc_output,
  output logic            fetch_valid,
  output logic            flush,
  output logic            misaligned,
  output logic [63:0]     fetch_count
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] INC_W    = XLEN'(INC);

  state_t          state;
  logic            pend_valid;
  src_t            pend_src;
  logic [XLEN-1:0] pend_target;

  src_t            live_src;
  src_t            sel_src;
  logic [XLEN-1:0] live_target;
  logic [XLEN-1:0] sel_target;

  pc_redirect_arbiter #(.XLEN(XLEN)) u_arbiter (
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .pend_valid    (pend_valid),
    .pend_src      (pend_src),
    .pend_target   (pend_target),
    .live_src      (live_src),
    .live_target   (live_target),
    .sel_src       (sel_src),
    .sel_target    (sel_target)
  );

  assign fetch_valid = (state == RUN) && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BOOT;
      pc_output   <= RESET_VECTOR;
      flush       <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
      pend_valid  <= 1'b0;
      pend_src    <= NONE;
      pend_target <= '0;
    end else begin
      state      <= RUN;
      flush      <= 1'b0;
      misaligned <= 1'b0;
      if ((state == BOOT) || stall) begin
        // PC frozen: keep the most important redirect seen so far.
        if ((live_src != NONE) && (!pend_valid || (live_src >= pend_src))) begin
          pend_valid  <= 1'b1;
          pend_src    <= live_src;
          pend_target <= live_target;
        end
      end else if (sel_src != NONE) begin
        pc_output   <= sel_target & ~LOW_MASK;
        misaligned  <= |(sel_target & LOW_MASK);
        flush       <= 1'b1;
        pend_valid  <= 1'b0;
        pend_src    <= NONE;
      end else if (fetch_ready) begin
        pc_output   <= pc_output + INC_W;
        fetch_count <= fetch_count + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - self-checking bench for pc_gen_unit
module tb_pc_gen_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1, stall = 1'b0, fetch_ready = 1'b0;
  logic        trap_valid = 1'b0, branch_valid = 1'b0, jump_valid = 1'b0;
  logic [31:0] trap_target = '0, branch_target = '0, jump_target = '0;
  logic [31:0] pc_output;
  logic        fetch_valid, flush, misaligned;
  logic [63:0] fetch_count;

  logic        s_reset = 1'b1, s_stall = 1'b0, s_fetch_ready = 1'b0;
  logic        s_trap_valid = 1'b0, s_branch_valid = 1'b0, s_jump_valid = 1'b0;
  logic [7:0]  s_trap_target = '0, s_branch_target = '0, s_jump_target = '0;
  logic [7:0]  s_pc_output;
  logic        s_fetch_valid, s_flush, s_misaligned;
  logic [63:0] s_fetch_count;

  int vectors = 0;
  int miscompares = 0;

  pc_gen_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pc_output(pc_output), .fetch_valid(fetch_valid), .flush(flush),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  pc_gen_unit #(.XLEN(8), .RESET_VECTOR(8'h00), .INC(4)) dut8 (
    .clock(clock), .reset(s_reset), .stall(s_stall), .fetch_ready(s_fetch_ready),
    .trap_valid(s_trap_valid), .trap_target(s_trap_target),
    .branch_valid(s_branch_valid), .branch_target(s_branch_target),
    .jump_valid(s_jump_valid), .jump_target(s_jump_target),
    .pc_output(s_pc_output), .fetch_valid(s_fetch_valid), .flush(s_flush),
    .misaligned(s_misaligned), .fetch_count(s_fetch_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_ready = 1'b1;
    tick(); tick();
    vectors += 5;
    if (pc_output !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_output, 32'h0); end
    if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b expected 0", flush); end
    if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
    if (fetch_count !== 64'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp_pc;
    reset = 1'b0;
    #1;
    vectors += 2;
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL boot_fetch_valid: got %b expected 0", fetch_valid); end
    if (pc_output !== 32'h0) begin miscompares++; $display("FAIL boot_pc: got %h expected %h", pc_output, 32'h0); end
    tick();
    vectors += 2;
    if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL run_fetch_valid: got %b expected 1", fetch_valid); end
    if (pc_output !== 32'h0) begin miscompares++; $display("FAIL run_first_pc: got %h expected %h", pc_output, 32'h0); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      vectors++;
      if (pc_output !== exp_pc) begin miscompares++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc_output, exp_pc); end
    end
    vectors++;
    if (fetch_count !== 64'd3) begin miscompares++; $display("FAIL seq_count: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_priority();
    trap_valid = 1'b1; trap_target = 32'h100;
    branch_valid = 1'b1; branch_target = 32'h200;
    jump_valid = 1'b1; jump_target = 32'h300;
    tick();
    trap_valid = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
    vectors += 3;
    if (pc_output !== 32'h100) begin miscompares++; $display("FAIL prio_pc: got %h expected %h", pc_output, 32'h100); end
    if (flush !== 1'b1) begin miscompares++; $display("FAIL prio_flush: got %b expected 1", flush); end
    if (fetch_count !== 64'd3) begin miscompares++; $display("FAIL prio_count_hold: got %0d expected 3", fetch_count); end
    tick();
    vectors += 3;
    if (flush !== 1'b0) begin miscompares++; $display("FAIL prio_flush_once: got %b expected 0", flush); end
    if (pc_output !== 32'h104) begin miscompares++; $display("FAIL prio_next_pc: got %h expected %h", pc_output, 32'h104); end
    if (fetch_count !== 64'd4) begin miscompares++; $display("FAIL prio_next_count: got %0d expected 4", fetch_count); end
  endtask

  task automatic test_stall_pending();
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h40;
    #1;
    vectors++;
    if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_fetch_valid: got %b expected 0", fetch_valid); end
    tick();
    branch_valid = 1'b0; jump_valid = 1'b1; jump_target = 32'h80;
    vectors += 2;
    if (pc_output !== 32'h104) begin miscompares++; $display("FAIL stall_hold1: got %h expected %h", pc_output, 32'h104); end
    if (flush !== 1'b0) begin miscompares++; $display("FAIL stall_flush1: got %b expected 0", flush); end
    tick();
    jump_valid = 1'b0; stall = 1'b0;
    vectors++;
    if (pc_output !== 32'h104) begin miscompares++; $display("FAIL stall_hold2: got %h expected %h", pc_output, 32'h104); end
    tick();
    vectors += 2;
    if (pc_output !== 32'h40) begin miscompares++; $display("FAIL pend_apply_pc: got %h expected %h", pc_output, 32'h40); end
    if (flush !== 1'b1) begin miscompares++; $display("FAIL pend_apply_flush: got %b expected 1", flush); end
    tick();
    vectors += 2;
    if (flush !== 1'b0) begin miscompares++; $display("FAIL pend_single_flush: got %b expected 0", flush); end
    if (pc_output !== 32'h44) begin miscompares++; $display("FAIL pend_after_pc: got %h expected %h", pc_output, 32'h44); end
  endtask

  task automatic test_misaligned();
    branch_valid = 1'b1; branch_target = 32'h103;
    tick();
    branch_valid = 1'b0;
    vectors += 2;
    if (pc_output !== 32'h100) begin miscompares++; $display("FAIL mis_pc: got %h expected %h", pc_output, 32'h100); end
    if (misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_pulse: got %b expected 1", misaligned); end
    tick();
    vectors += 2;
    if (misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_one_cycle: got %b expected 0", misaligned); end
    if (pc_output !== 32'h104) begin miscompares++; $display("FAIL mis_next_pc: got %h expected %h", pc_output, 32'h104); end
  endtask

  task automatic test_wrap_xlen8();
    s_reset = 1'b1; tick();
    s_reset = 1'b0; s_fetch_ready = 1'b0;
    s_branch_valid = 1'b1; s_branch_target = 8'hFC;
    #1;
    vectors++;
    if (s_fetch_valid !== 1'b0) begin miscompares++; $display("FAIL w8_boot_fv: got %b expected 0", s_fetch_valid); end
    tick();
    s_branch_valid = 1'b0;
    vectors++;
    if (s_pc_output !== 8'h00) begin miscompares++; $display("FAIL w8_boot_pc: got %h expected 00", s_pc_output); end
    tick();
    vectors += 2;
    if (s_pc_output !== 8'hFC) begin miscompares++; $display("FAIL w8_boot_capture: got %h expected FC", s_pc_output); end
    if (s_fetch_count !== 64'd0) begin miscompares++; $display("FAIL w8_count0: got %0d expected 0", s_fetch_count); end
    s_fetch_ready = 1'b1;
    tick();
    vectors += 2;
    if (s_pc_output !== 8'h00) begin miscompares++; $display("FAIL w8_wrap_pc: got %h expected 00", s_pc_output); end
    if (s_fetch_count !== 64'd1) begin miscompares++; $display("FAIL w8_wrap_count: got %0d expected 1", s_fetch_count); end
    s_fetch_ready = 1'b0;
    tick();
    vectors += 2;
    if (s_pc_output !== 8'h00) begin miscompares++; $display("FAIL w8_hold_pc: got %h expected 00", s_pc_output); end
    if (s_fetch_count !== 64'd1) begin miscompares++; $display("FAIL w8_hold_count: got %0d expected 1", s_fetch_count); end
  endtask

  task automatic test_reset_pending();
    stall = 1'b1; trap_valid = 1'b1; trap_target = 32'h500;
    tick();
    trap_valid = 1'b0; reset = 1'b1;
    tick();
    vectors += 2;
    if (pc_output !== 32'h0) begin miscompares++; $display("FAIL rstp_pc: got %h expected %h", pc_output, 32'h0); end
    if (flush !== 1'b0) begin miscompares++; $display("FAIL rstp_flush: got %b expected 0", flush); end
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
    tick();
    tick();
    vectors += 2;
    if (flush !== 1'b0) begin miscompares++; $display("FAIL rstp_no_flush: got %b expected 0", flush); end
    if (pc_output !== 32'h0) begin miscompares++; $display("FAIL rstp_pc_after: got %h expected %h", pc_output, 32'h0); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_pend_tgt, lt, st;
    logic [63:0] m_cnt;
    bit          m_run, m_flush, m_mis;
    int          m_pend_pri, lp, sp;
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b0;
    trap_valid = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
    tick();
    m_pc = 32'h0; m_cnt = 64'd0; m_run = 0; m_flush = 0; m_mis = 0;
    m_pend_pri = 0; m_pend_tgt = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(63) == 0);
      stall         = ($urandom_range(2) == 0);
      fetch_ready   = ($urandom_range(3) != 0);
      trap_valid    = ($urandom_range(9) == 0);
      branch_valid  = ($urandom_range(6) == 0);
      jump_valid    = ($urandom_range(6) == 0);
      trap_target   = $urandom;
      branch_target = $urandom;
      jump_target   = $urandom;
      #1;
      vectors++;
      if (fetch_valid !== (m_run && !stall)) begin
        miscompares++; $display("FAIL rnd_fetch_valid[%0d]: got %b expected %b", n, fetch_valid, m_run && !stall);
      end
      if (reset) begin
        m_pc = 32'h0; m_cnt = 64'd0; m_run = 0; m_flush = 0; m_mis = 0;
        m_pend_pri = 0; m_pend_tgt = 32'h0;
      end else begin
        lp = trap_valid ? 3 : branch_valid ? 2 : jump_valid ? 1 : 0;
        lt = trap_valid ? trap_target : branch_valid ? branch_target : jump_target;
        m_flush = 0; m_mis = 0;
        if (!m_run || stall) begin
          if (lp != 0 && lp >= m_pend_pri) begin m_pend_pri = lp; m_pend_tgt = lt; end
        end else begin
          if (m_pend_pri != 0 && m_pend_pri >= lp) begin sp = m_pend_pri; st = m_pend_tgt; end
          else begin sp = lp; st = lt; end
          if (sp != 0) begin
            m_pc = st - (st % 4); m_mis = (st % 4) != 0; m_flush = 1; m_pend_pri = 0;
          end else if (fetch_ready) begin
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 64'd1;
          end
        end
        m_run = 1;
      end
      tick();
      vectors += 4;
      if (pc_output !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc_output, m_pc); end
      if (flush !== m_flush) begin miscompares++; $display("FAIL rnd_flush[%0d]: got %b expected %b", n, flush, m_flush); end
      if (misaligned !== m_mis) begin miscompares++; $display("FAIL rnd_misaligned[%0d]: got %b expected %b", n, misaligned, m_mis); end
      if (fetch_count !== m_cnt) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, fetch_count, m_cnt); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_boot_sequence();
    test_priority();
    test_stall_pending();
    test_misaligned();
    test_wrap_xlen8();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
